pll_lock_supervisor: RTL and testbench
======================================

# pll_lock_supervisor

Reset and lock supervisor that sits directly upstream of the 4-output phase-shift PLL wrapper. It drives the PLL's active-high `rst` and watches its `locked` output, synchronized into `refclk`. It generates a minimum-width PLL reset pulse, qualifies lock stability, retries on lock timeout and recovers from loss of lock. Downstream logic sees a single clean, gated system reset, `sys_rst_n`.

## Interface
- `RST_PULSE_CYC`, 16: `pll_rst` high time per reset attempt, in cycles; ≥2.
- `LOCK_STABLE_CYC`, 256: consecutive synchronized-lock cycles required before release; ≥1.
- `LOCK_TIMEOUT_CYC`, 65536: maximum cycles waiting for lock per attempt; ≥2.
- `MAX_RETRY`, 3: re-attempts after the first before declaring failure; ≥0.
- `refclk` in 1: free-running reference clock, the same clock that feeds the PLL. It is the block's only clock.
- `rst_n` in 1: reset, asynchronous, active-low. Deassertion is synchronized to `refclk` upstream.
- `pll_locked` in 1: PLL `locked`, asynchronous to `refclk`.
- `relock_req` in 1: single-cycle pulse that forces a new PLL reset cycle.
- `pll_rst` out 1: to the PLL `rst`, active-high.
- `sys_rst_n` out 1: active-low reset for logic clocked by the PLL outputs.
- `ready` out 1: PLL locked and qualified.
- `fail` out 1: retries exhausted.
- `retry_cnt` out clog2(MAX_RETRY+1): retries used in the current acquisition.
- `loss_cnt` out 8: lock-loss events while in RUN, saturating.

## Operation
- `pll_locked` passes through a 2-flop synchronizer to give `locked_s`.
- States:
  - **RESET_PLL**: `pll_rst`=1. After `RST_PULSE_CYC` cycles → WAIT_LOCK, timer cleared.
  - **WAIT_LOCK**: `pll_rst`=0.
    - `locked_s`=1 → STABLE, stable counter cleared.
    - Timer reaches `LOCK_TIMEOUT_CYC`-1 with `retry_cnt`==`MAX_RETRY` → FAIL.
    - Timer reaches `LOCK_TIMEOUT_CYC`-1 otherwise → `retry_cnt`+1 and RESET_PLL.
  - **STABLE**:
    - `locked_s`=0 → WAIT_LOCK, timer cleared, retry not consumed.
    - `LOCK_STABLE_CYC` consecutive `locked_s`=1 cycles → RUN, `retry_cnt` cleared.
  - **RUN**: `sys_rst_n`=1, `ready`=1.
    - `locked_s`=0 → `loss_cnt`+1 (saturates at 255) and RESET_PLL.
    - `relock_req` → RESET_PLL without incrementing `loss_cnt`.
  - **FAIL**: `pll_rst`=1 held, `fail`=1.
    - Exit only via `rst_n`, or via `relock_req`, which clears `retry_cnt` and goes to RESET_PLL.
- Outside RUN: `sys_rst_n`=0, `ready`=0.
- `relock_req` in RESET_PLL, WAIT_LOCK or STABLE:
  - Restarts RESET_PLL with the pulse counter cleared.
  - `retry_cnt` unchanged.
- Simultaneous lock drop and `relock_req` in RUN counts as a loss (`loss_cnt`+1).
- `loss_cnt` is cleared only by `rst_n`.

## Timing
- Reset values, applied asynchronously on `rst_n` low:
  - `pll_rst`=1, `sys_rst_n`=0, `ready`=0, `fail`=0.
  - `retry_cnt`=0, `loss_cnt`=0.
  - State RESET_PLL, all counters 0.
- All outputs are registered and decoded from next-state, so they change on the same edge as the state.
- `pll_rst` stays high exactly `RST_PULSE_CYC` cycles after `rst_n` deasserts and after every entry into RESET_PLL.
- Synchronizer latency is 2 cycles: a `pll_locked` edge affects state on the 3rd rising edge.
- `ready`/`sys_rst_n` rise `LOCK_STABLE_CYC` cycles after STABLE is entered, if lock holds throughout.
- A lock drop in RUN deasserts `ready`/`sys_rst_n` ≤3 cycles after the `pll_locked` fall.
- Counter widths are derived with clog2 of each limit; no counter wraps.
- Reset mid-operation aborts immediately; there is no pending state.

## Structure
- Package `pll_sup_pkg`:
  - State enum `pll_sup_state_t` (RESET_PLL, WAIT_LOCK, STABLE, RUN, FAIL).
  - `LOSS_CNT_W`=8.
  - `SYNC_STAGES`=2.
- Sub-module `pll_sync2`: 2-flop synchronizer with async active-low reset to 0. It is reused for other asynchronous status inputs.
- Top level: FSM, pulse/stable/timeout counters (one shared counter is allowed), `retry_cnt`, `loss_cnt`.

## Test plan
Bench parameters: `RST_PULSE_CYC`=4, `LOCK_STABLE_CYC`=8, `LOCK_TIMEOUT_CYC`=32, `MAX_RETRY`=2.
- **Normal lock**: `pll_locked` rises 10 cycles after `pll_rst` falls → `ready`=1 and `sys_rst_n`=1 exactly 2+8 cycles later; `retry_cnt`=0.
- **Glitch during STABLE**: `pll_locked` low for 1 cycle after 5 stable cycles → no `ready`; `ready` rises 8 cycles after `locked_s` returns high; `retry_cnt`=0.
- **Timeout**: `pll_locked` held 0 → three 4-cycle `pll_rst` pulses spaced by 32-cycle waits; then `fail`=1, `pll_rst`=1 held, `retry_cnt`=2.
- **Loss in RUN**: drop `pll_locked` → `sys_rst_n`=0 within 3 cycles; `loss_cnt`=1; 4-cycle `pll_rst` pulse; after relock, `ready`=1 again. Repeat 260 times → `loss_cnt`=255.
- **Manual relock**:
  - `relock_req` in FAIL → `fail`=0, `retry_cnt`=0, new 4-cycle pulse.
  - `relock_req` in RUN → `loss_cnt` unchanged.
- **Async reset**: `rst_n` low mid-WAIT_LOCK, between clock edges → all outputs at reset values before the next edge.

Source files
------------

// File: rtl/pll_sup_pkg.sv
// Shared types and constants for the PLL reset/lock supervisor and its helpers.
package pll_sup_pkg;

  typedef enum logic [2:0] {
    RESET_PLL = 3'd0,
    WAIT_LOCK = 3'd1,
    STABLE    = 3'd2,
    RUN       = 3'd3,
    FAIL      = 3'd4
  } pll_sup_state_t;

  localparam int unsigned LOSS_CNT_W  = 8;
  localparam int unsigned SYNC_STAGES = 2;

  localparam logic [LOSS_CNT_W-1:0] LOSS_CNT_MAX = '1;

  // Bits needed to hold 0..limit-1; never narrower than one bit.
  function automatic int unsigned cnt_w(input int unsigned limit);
    int unsigned w;
    w = 1;
    while ((w < 32) && ((32'd1 << w) < limit)) begin
      w = w + 1;
    end
    return w;
  endfunction

  function automatic int unsigned max3(input int unsigned a,
                                       input int unsigned b,
                                       input int unsigned c);
    int unsigned m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/pll_sync2.sv
// Multi-flop synchronizer for slow asynchronous status bits; resets to 0.
module pll_sync2
  import pll_sup_pkg::*;
#(
  parameter int unsigned WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [SYNC_STAGES-1:0][WIDTH-1:0] stage_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stage_q <= '0;
    end else begin
      stage_q <= {stage_q[SYNC_STAGES-2:0], d};
    end
  end

  assign q = stage_q[SYNC_STAGES-1];

endmodule

// File: rtl/pll_lock_supervisor.sv
// PLL reset pulse generation, lock qualification, timeout retry and loss recovery;
// produces the gated system reset for logic clocked by the PLL outputs.
module pll_lock_supervisor
  import pll_sup_pkg::*;
#(
  parameter int unsigned RST_PULSE_CYC    = 16,
  parameter int unsigned LOCK_STABLE_CYC  = 256,
  parameter int unsigned LOCK_TIMEOUT_CYC = 65536,
  parameter int unsigned MAX_RETRY        = 3
) (
  input  logic                              refclk,
  input  logic                              rst_n,
  input  logic                              pll_locked,
  input  logic                              relock_req,
  output logic                              pll_rst,
  output logic                              sys_rst_n,
  output logic                              ready,
  output logic                              fail,
  output logic [cnt_w(MAX_RETRY + 1)-1:0]   retry_cnt,
  output logic [LOSS_CNT_W-1:0]             loss_cnt
);

  localparam int unsigned RETRY_W = cnt_w(MAX_RETRY + 1);
  localparam int unsigned CNT_W   = cnt_w(max3(RST_PULSE_CYC, LOCK_STABLE_CYC, LOCK_TIMEOUT_CYC));

  localparam logic [CNT_W-1:0]   PULSE_LAST   = CNT_W'(RST_PULSE_CYC - 1);
  localparam logic [CNT_W-1:0]   TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT_CYC - 1);
  // The WAIT_LOCK->STABLE edge already saw one good lock cycle, so the
  // counter in STABLE tracks the qualified cycles beyond that first one.
  localparam logic [CNT_W-1:0]   STABLE_LAST  =
    CNT_W'((LOCK_STABLE_CYC > 1) ? (LOCK_STABLE_CYC - 2) : 0);
  localparam logic [RETRY_W-1:0] RETRY_LAST   = RETRY_W'(MAX_RETRY);

  logic                  locked_s;
  pll_sup_state_t        state_q;
  pll_sup_state_t        state_d;
  logic [CNT_W-1:0]      cnt_q;
  logic [CNT_W-1:0]      cnt_d;
  logic [RETRY_W-1:0]    retry_d;
  logic [LOSS_CNT_W-1:0] loss_d;

  pll_sync2 #(
    .WIDTH (1)
  ) u_lock_sync (
    .clk   (refclk),
    .rst_n (rst_n),
    .d     (pll_locked),
    .q     (locked_s)
  );

  // Next-state, shared pulse/timeout/stable counter, retry and loss bookkeeping.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    retry_d = retry_cnt;
    loss_d  = loss_cnt;

    case (state_q)
      RESET_PLL: begin
        if (relock_req) begin
          cnt_d = '0;
        end else if (cnt_q == PULSE_LAST) begin
          state_d = WAIT_LOCK;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      WAIT_LOCK: begin
        if (relock_req) begin
          state_d = RESET_PLL;
          cnt_d   = '0;
        end else if (locked_s) begin
          state_d = STABLE;
          cnt_d   = '0;
        end else if (cnt_q == TIMEOUT_LAST) begin
          cnt_d = '0;
          if (retry_cnt == RETRY_LAST) begin
            state_d = FAIL;
          end else begin
            state_d = RESET_PLL;
            retry_d = retry_cnt + RETRY_W'(1);
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      STABLE: begin
        if (relock_req) begin
          state_d = RESET_PLL;
          cnt_d   = '0;
        end else if (!locked_s) begin
          state_d = WAIT_LOCK;
          cnt_d   = '0;
        end else if (cnt_q == STABLE_LAST) begin
          state_d = RUN;
          cnt_d   = '0;
          retry_d = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      RUN: begin
        cnt_d = '0;
        // A lock drop wins over a coincident relock request and is counted.
        if (!locked_s) begin
          state_d = RESET_PLL;
          if (loss_cnt != LOSS_CNT_MAX) begin
            loss_d = loss_cnt + LOSS_CNT_W'(1);
          end
        end else if (relock_req) begin
          state_d = RESET_PLL;
        end
      end

      FAIL: begin
        cnt_d = '0;
        if (relock_req) begin
          state_d = RESET_PLL;
          retry_d = '0;
        end
      end

      default: begin
        state_d = RESET_PLL;
        cnt_d   = '0;
      end
    endcase
  end

  // State, counters and outputs decoded from next-state share one edge.
  always_ff @(posedge refclk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= RESET_PLL;
      cnt_q     <= '0;
      retry_cnt <= '0;
      loss_cnt  <= '0;
      pll_rst   <= 1'b1;
      sys_rst_n <= 1'b0;
      ready     <= 1'b0;
      fail      <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      retry_cnt <= retry_d;
      loss_cnt  <= loss_d;
      pll_rst   <= (state_d == RESET_PLL) || (state_d == FAIL);
      sys_rst_n <= (state_d == RUN);
      ready     <= (state_d == RUN);
      fail      <= (state_d == FAIL);
    end
  end

endmodule

// File: tb/tb_pll_lock_supervisor.sv
// Randomized and directed bench for pll_lock_supervisor against an elapsed-time
// phase model of the supervisor's rules.
module tb_pll_lock_supervisor;

  localparam int unsigned P_PULSE   = 4;
  localparam int unsigned P_STABLE  = 8;
  localparam int unsigned P_TIMEOUT = 32;
  localparam int unsigned P_MAXR    = 2;
  localparam int          RW        = 2;

  localparam int PH_RST  = 0;
  localparam int PH_WAIT = 1;
  localparam int PH_QUAL = 2;
  localparam int PH_RUN  = 3;
  localparam int PH_DEAD = 4;

  logic          refclk     = 1'b0;
  logic          rst_n      = 1'b0;
  logic          pll_locked = 1'b0;
  logic          relock_req = 1'b0;
  logic          pll_rst;
  logic          sys_rst_n;
  logic          ready;
  logic          fail;
  logic [RW-1:0] retry_cnt;
  logic [7:0]    loss_cnt;

  int checks   = 0;
  int failures = 0;
  bit chk_en   = 1'b0;

  pll_lock_supervisor #(
    .RST_PULSE_CYC    (P_PULSE),
    .LOCK_STABLE_CYC  (P_STABLE),
    .LOCK_TIMEOUT_CYC (P_TIMEOUT),
    .MAX_RETRY        (P_MAXR)
  ) dut (
    .refclk     (refclk),
    .rst_n      (rst_n),
    .pll_locked (pll_locked),
    .relock_req (relock_req),
    .pll_rst    (pll_rst),
    .sys_rst_n  (sys_rst_n),
    .ready      (ready),
    .fail       (fail),
    .retry_cnt  (retry_cnt),
    .loss_cnt   (loss_cnt)
  );

  always #5 refclk = ~refclk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
    end
  endtask

  // Model: phase plus the edge index it was entered on; lock seen two edges late.
  int cyc     = 0;
  int start   = 0;
  int ph      = PH_RST;
  int m_retry = 0;
  int m_loss  = 0;
  int el      = 0;
  bit h1      = 1'b0;
  bit h2      = 1'b0;
  bit ls      = 1'b0;

  task automatic enter(input int p);
    ph    = p;
    start = cyc;
  endtask

  initial forever begin
    @(posedge refclk or negedge rst_n);
    if (!rst_n) begin
      ph      = PH_RST;
      start   = cyc;
      m_retry = 0;
      m_loss  = 0;
      h1      = 1'b0;
      h2      = 1'b0;
    end else begin
      cyc++;
      ls = h2;
      h2 = h1;
      h1 = pll_locked;
      el = cyc - start;
      case (ph)
        PH_RST: begin
          if (relock_req) enter(PH_RST);
          else if (el == int'(P_PULSE)) enter(PH_WAIT);
        end
        PH_WAIT: begin
          if (relock_req) enter(PH_RST);
          else if (ls) enter(PH_QUAL);
          else if (el == int'(P_TIMEOUT)) begin
            if (m_retry == int'(P_MAXR)) enter(PH_DEAD);
            else begin
              m_retry++;
              enter(PH_RST);
            end
          end
        end
        PH_QUAL: begin
          if (relock_req) enter(PH_RST);
          else if (!ls) enter(PH_WAIT);
          else if (el + 1 >= int'(P_STABLE)) begin
            m_retry = 0;
            enter(PH_RUN);
          end
        end
        PH_RUN: begin
          if (!ls) begin
            if (m_loss < 255) m_loss++;
            enter(PH_RST);
          end else if (relock_req) enter(PH_RST);
        end
        default: begin
          if (relock_req) begin
            m_retry = 0;
            enter(PH_RST);
          end
        end
      endcase
    end
  end

  // Per-cycle comparison against the model, away from the active edge.
  initial forever begin
    @(negedge refclk);
    if (chk_en) begin
      chk("m_pll_rst",   32'(pll_rst),   32'((ph == PH_RST) || (ph == PH_DEAD)));
      chk("m_sys_rst_n", 32'(sys_rst_n), 32'(ph == PH_RUN));
      chk("m_ready",     32'(ready),     32'(ph == PH_RUN));
      chk("m_fail",      32'(fail),      32'(ph == PH_DEAD));
      chk("m_retry_cnt", 32'(retry_cnt), 32'(m_retry));
      chk("m_loss_cnt",  32'(loss_cnt),  32'(m_loss));
    end
  end

  function automatic logic sig(input int sel);
    case (sel)
      0:       return pll_rst;
      1:       return ready;
      2:       return sys_rst_n;
      default: return fail;
    endcase
  endfunction

  // Negedges advanced until the selected output equals val (bounded).
  task automatic wait_sig(input string name, input int sel, input logic val,
                          input int max_cyc, output int n);
    n = 0;
    while (sig(sel) !== val) begin
      if (n >= max_cyc) begin
        checks++;
        failures++;
        $display("FAIL %s no change within %0d cycles at %0t", name, max_cyc, $time);
        return;
      end
      @(negedge refclk);
      n++;
    end
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_pll_rst"},   32'(pll_rst),   1);
    chk({tag, "_sys_rst_n"}, 32'(sys_rst_n), 0);
    chk({tag, "_ready"},     32'(ready),     0);
    chk({tag, "_fail"},      32'(fail),      0);
    chk({tag, "_retry"},     32'(retry_cnt), 0);
    chk({tag, "_loss"},      32'(loss_cnt),  0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    repeat (3) @(negedge refclk);
    chk_reset_vals("reset");
    chk_en = 1'b1;
    rst_n  = 1'b1;

    // Normal lock
    wait_sig("first_pulse", 0, 1'b0, 50, n);
    chk("first_pulse_len", n, 4);
    repeat (9) @(negedge refclk);
    pll_locked = 1'b1;
    wait_sig("normal_ready", 1, 1'b1, 100, n);
    chk("normal_ready_lat", n, 10);
    chk("normal_sys_rst_n", 32'(sys_rst_n), 1);
    chk("normal_retry", 32'(retry_cnt), 0);

    // Loss in RUN
    pll_locked = 1'b0;
    wait_sig("loss_deassert", 2, 1'b0, 10, n);
    chk("loss_deassert_le3", 32'(n <= 3), 1);
    chk("loss_cnt_1", 32'(loss_cnt), 1);
    wait_sig("loss_pulse", 0, 1'b0, 50, n);
    chk("loss_pulse_len", n, 4);
    repeat (3) @(negedge refclk);
    pll_locked = 1'b1;
    wait_sig("loss_relock", 1, 1'b1, 100, n);
    chk("loss_relock_lat", n, 10);

    // Manual relock in RUN
    relock_req = 1'b1;
    pll_locked = 1'b0;
    @(negedge refclk);
    relock_req = 1'b0;
    chk("relock_run_ready", 32'(ready), 0);
    chk("relock_run_loss", 32'(loss_cnt), 1);
    wait_sig("relock_run_pulse", 0, 1'b0, 50, n);
    chk("relock_run_pulse_len", n, 4);

    // Glitch during STABLE
    pll_locked = 1'b1;
    repeat (5) @(negedge refclk);
    pll_locked = 1'b0;
    @(negedge refclk);
    pll_locked = 1'b1;
    wait_sig("glitch_ready", 1, 1'b1, 100, n);
    chk("glitch_ready_lat", n, 10);
    chk("glitch_retry", 32'(retry_cnt), 0);

    // Repeated losses up to saturation
    for (int i = 0; i < 259; i++) begin
      pll_locked = 1'b0;
      wait_sig("loop_drop", 2, 1'b0, 10, n);
      wait_sig("loop_pulse", 0, 1'b0, 50, n);
      repeat ($urandom_range(0, 12)) @(negedge refclk);
      pll_locked = 1'b1;
      wait_sig("loop_ready", 1, 1'b1, 100, n);
      repeat ($urandom_range(0, 6)) @(negedge refclk);
    end
    chk("loss_saturated", 32'(loss_cnt), 255);

    // Timeout and retries
    relock_req = 1'b1;
    pll_locked = 1'b0;
    @(negedge refclk);
    relock_req = 1'b0;
    for (int a = 0; a < 3; a++) begin
      wait_sig("to_pulse", 0, 1'b0, 50, n);
      chk("to_pulse_len", n, 4);
      wait_sig("to_wait", 0, 1'b1, 100, n);
      chk("to_wait_len", n, 32);
    end
    chk("to_fail", 32'(fail), 1);
    chk("to_retry", 32'(retry_cnt), 2);
    repeat (40) @(negedge refclk);
    chk("to_fail_hold_rst", 32'(pll_rst), 1);
    chk("to_fail_hold", 32'(fail), 1);
    chk("to_loss_kept", 32'(loss_cnt), 255);

    // Manual relock from FAIL
    relock_req = 1'b1;
    @(negedge refclk);
    relock_req = 1'b0;
    chk("relock_fail_fail", 32'(fail), 0);
    chk("relock_fail_retry", 32'(retry_cnt), 0);
    chk("relock_fail_pll_rst", 32'(pll_rst), 1);
    wait_sig("relock_fail_pulse", 0, 1'b0, 50, n);
    chk("relock_fail_pulse_len", n, 4);

    // Async reset between edges, mid WAIT_LOCK
    repeat (5) @(negedge refclk);
    @(posedge refclk);
    #3;
    rst_n = 1'b0;
    #1;
    chk_reset_vals("async");
    @(negedge refclk);
    @(negedge refclk);
    rst_n = 1'b1;
    wait_sig("post_reset_pulse", 0, 1'b0, 50, n);
    chk("post_reset_pulse_len", n, 4);

    // Random lock activity and relock requests
    for (int i = 0; i < 3000; i++) begin
      @(negedge refclk);
      if ($urandom_range(0, 19) == 0) pll_locked = ~pll_locked;
      relock_req = ($urandom_range(0, 59) == 0);
    end
    @(negedge refclk);
    relock_req = 1'b0;
    repeat (2) @(negedge refclk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
